// File: rtl/systolic_wavefront_scheduler.sv
// systolic_wavefront_scheduler
//
// Runs one N x N processing-element array through a single matrix-multiply
// pass of reduction length K. Each array row gets its own input_start pulses.
// Each row is skewed by one cycle against the row above, so the operands
// enter the array as a diagonal wavefront. The wavefront freezes while the
// array reports a stall. Result pulses from the far-corner PE are counted, and
// done is pulsed once k_eff results have arrived.
//
// Optional feature: define SCHED_PERF_CNT_EN to count ISSUE cycles that spend
// time stalled. Without it, perf_stall_cycles is tied to zero.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, cfg_k       begin a pass with reduction length cfg_k (clamped to K_MAX)
//   abort              level; terminate the current pass without done
//   array_stall        OR of all PE stall outputs
//   last_pe_ready      data_ready of PE (N-1,N-1)
//   row_start          per-row input_start
//   clr_psum           one-cycle pulse that zeroes the PE partial sums
//   issue_step         current wavefront step (0 outside ISSUE)
//   busy               high whenever the scheduler is not IDLE
//   done               one-cycle completion pulse
//   perf_stall_cycles  stalled ISSUE cycle count (zero unless SCHED_PERF_CNT_EN)
//
// Handshake: start has no ready signal. It is accepted only in a cycle where
// busy is low. A start seen while busy is high, including the DONE cycle, is
// dropped.
module systolic_wavefront_scheduler #(
  parameter int N     = 4,
  parameter int K_MAX = 16,
  parameter int KW    = $clog2(K_MAX + 1),
  parameter int SW    = $clog2(K_MAX + N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] cfg_k,
  input  logic          abort,
  input  logic          array_stall,
  input  logic          last_pe_ready,
  output logic [N-1:0]  row_start,
  output logic          clr_psum,
  output logic [SW-1:0] issue_step,
  output logic          busy,
  output logic          done,
  output logic [31:0]   perf_stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_eff_q, k_eff_d;
  logic [SW-1:0] step_q, step_d;
  logic [KW-1:0] res_cnt_q, res_cnt_d;

  logic [KW-1:0] k_clamped;
  logic [SW:0]   last_step;
  logic [SW:0]   step_ext;
  logic [SW:0]   k_ext;
  logic [N-1:0]  row_mask;
  logic          counting;

  assign k_clamped = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;

  // Widen to SW+1 bits so that k_eff + r and k_eff + N - 2 cannot wrap.
  assign step_ext  = {1'b0, step_q};
  assign k_ext     = (SW+1)'(k_eff_q);
  assign last_step = k_ext + (SW+1)'(N) - (SW+1)'(2);

  // Row r is inside the wavefront while r <= s < k_eff + r.
  always_comb begin
    row_mask = '0;
    for (int r = 0; r < N; r++) begin
      row_mask[r] = (step_ext >= (SW+1)'(r)) && (step_ext < k_ext + (SW+1)'(r));
    end
  end

  assign counting = (state_q == S_LOAD) || (state_q == S_ISSUE) || (state_q == S_DRAIN);

  always_comb begin
    state_d    = state_q;
    k_eff_d    = k_eff_q;
    step_d     = step_q;
    res_cnt_d  = res_cnt_q;
    row_start  = '0;
    clr_psum   = 1'b0;
    issue_step = '0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;

    // The result count saturates at k_eff. Extra corner pulses are ignored.
    if (counting && last_pe_ready && (res_cnt_q != k_eff_q)) begin
      res_cnt_d = res_cnt_q + KW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_eff_d   = k_clamped;
          step_d    = '0;
          res_cnt_d = '0;
          state_d   = (k_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        clr_psum = 1'b1;
        step_d   = '0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        issue_step = step_q;
        if (!array_stall) begin
          row_start = row_mask;
          if (step_ext == last_step) begin
            state_d = S_DRAIN;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Look at the count including this cycle's pulse. That way done
        // follows the final result by exactly one cycle.
        if (res_cnt_d == k_eff_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort cuts the pulses in the same cycle and returns to IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      row_start = '0;
      clr_psum  = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_eff_q   <= '0;
      step_q    <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      k_eff_q   <= k_eff_d;
      step_q    <= step_d;
      res_cnt_q <= res_cnt_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Cleared in LOAD. Counts stalled ISSUE cycles and saturates at all ones.
  // Between passes it keeps its last value.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_LOAD) begin
      perf_d = '0;
    end else if ((state_q == S_ISSUE) && array_stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_wavefront_scheduler.sv
// Self-checking bench for systolic_wavefront_scheduler (N=4, K_MAX=16).
// Stimulus is driven one clock at a time, 1 time unit after the rising edge.
// Each driven cycle pushes the expected output vector
// {row_start, clr_psum, issue_step, busy, done} into exp_q. A monitor on the
// falling edge pops that entry and compares it against the DUT outputs.
module tb_systolic_wavefront_scheduler;
  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int KW    = 5;
  localparam int SW    = 5;
  localparam int W     = N + SW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] cfg_k;
  logic          abort;
  logic          array_stall;
  logic          last_pe_ready;
  logic [N-1:0]  row_start;
  logic          clr_psum;
  logic [SW-1:0] issue_step;
  logic          busy;
  logic          done;
  logic [31:0]   perf_stall_cycles;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  systolic_wavefront_scheduler #(.N(N), .K_MAX(K_MAX)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_k             (cfg_k),
    .abort             (abort),
    .array_stall       (array_stall),
    .last_pe_ready     (last_pe_ready),
    .row_start         (row_start),
    .clr_psum          (clr_psum),
    .issue_step        (issue_step),
    .busy              (busy),
    .done              (done),
    .perf_stall_cycles (perf_stall_cycles)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_checks  = 0;
  int n_errors  = 0;
  int row0_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [N-1:0] rs, input logic clr, input int st,
                                      input logic bz, input logic dn);
    logic [SW-1:0] s5;
    s5 = SW'(st);
    return {rs, clr, s5, bz, dn};
  endfunction

  // Rows active at wavefront step s: r <= s < k + r.
  function automatic logic [N-1:0] rows_at(input int s, input int k);
    logic [N-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) if (s >= r && s < k + r) v[r] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq("outs{row,clr,step,busy,done}",
               32'({row_start, clr_psum, issue_step, busy, done}), 32'(mon_e));
    end
    if (row_start[0] === 1'b1) row0_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step_cyc(input logic st, input logic [KW-1:0] ck, input logic ab,
                          input logic stl, input logic lpr, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    start         = st;
    cfg_k         = ck;
    abort         = ab;
    array_stall   = stl;
    last_pe_ready = lpr;
    exp_q.push_back(e);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) step_cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic start_cyc(input int k);
    step_cyc(1'b1, KW'(k), 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load_cyc(input logic stl, input logic lpr);
    step_cyc(1'b0, '0, 1'b0, stl, lpr, mk('0, 1'b1, 0, 1'b1, 1'b0));
  endtask

  task automatic drain_cyc(input logic st, input logic stl, input logic lpr);
    step_cyc(st, KW'(3), 1'b0, stl, lpr, mk('0, 1'b0, 0, 1'b1, 1'b0));
  endtask

  task automatic done_cyc(input logic st, input logic lpr);
    step_cyc(st, KW'(3), 1'b0, 1'b0, lpr, mk('0, 1'b0, 0, 1'b1, 1'b1));
  endtask

  // Walks n_steps wavefront steps. At step stall_s the array stalls for
  // stall_len cycles first. last_pe_ready is high for steps below lpr_until.
  task automatic issue_phase(input int k, input int stall_s, input int stall_len,
                             input int lpr_until, input int n_steps);
    for (int s = 0; s < n_steps; s++) begin
      logic l;
      l = (s < lpr_until);
      if (s == stall_s) begin
        for (int j = 0; j < stall_len; j++)
          step_cyc(1'b0, '0, 1'b0, 1'b1, l, mk('0, 1'b0, s, 1'b1, 1'b0));
      end
      step_cyc(1'b0, '0, 1'b0, 1'b0, l, mk(rows_at(s, k), 1'b0, s, 1'b1, 1'b0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; cfg_k = '0; abort = 1'b0;
    array_stall = 1'b0; last_pe_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_perf", perf_stall_cycles, 32'd0);
    idle_cyc(2);

    // Basic pass k=3. Timing is written in absolute cycles from start.
    row0_cnt = 0;
    start_cyc(3);                                         // cycle 0
    load_cyc(1'b0, 1'b0);                                 // cycle 1: clr_psum
    for (int c = 2; c <= 3 + N; c++) begin
      logic [N-1:0] rs;
      rs = '0;
      for (int r = 0; r < N; r++) rs[r] = (c >= 2 + r) && (c <= 3 + 1 + r);
      step_cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, mk(rs, 1'b0, c - 2, 1'b1, 1'b0));
    end
    repeat (3) drain_cyc(1'b0, 1'b0, 1'b1);               // cycles 8..10
    done_cyc(1'b0, 1'b0);                                 // cycle 11
    idle_cyc(2);
    check_eq("basic_row0_pulses", row0_cnt, 32'd3);

    // Stall for 2 cycles at s=1.
    row0_cnt = 0;
    start_cyc(3);
    load_cyc(1'b0, 1'b0);
    issue_phase(3, 1, 2, 0, 3 + N - 1);
    repeat (3) drain_cyc(1'b0, 1'b0, 1'b1);
    done_cyc(1'b0, 1'b0);
    idle_cyc(1);
    check_eq("stall_row0_pulses", row0_cnt, 32'd3);
`ifdef SCHED_PERF_CNT_EN
    check_eq("stall_perf", perf_stall_cycles, 32'd2);
`else
    check_eq("stall_perf", perf_stall_cycles, 32'd0);
`endif

    // k = 0: done the cycle after start, with no clr_psum and no rows.
    start_cyc(0);
    done_cyc(1'b0, 1'b0);
    idle_cyc(2);

    // cfg_k = 31 is clamped to 16. Results stream in during ISSUE and
    // saturate the count.
    row0_cnt = 0;
    start_cyc(31);
    load_cyc(1'b0, 1'b0);
    issue_phase(K_MAX, -1, 0, 100, K_MAX + N - 1);
    drain_cyc(1'b0, 1'b0, 1'b0);
    done_cyc(1'b0, 1'b0);
    idle_cyc(1);
    check_eq("clamp_row0_pulses", row0_cnt, 32'(K_MAX));

    // Abort at s=2, then a clean k=2 pass. Stall outside ISSUE is ignored.
    start_cyc(3);
    load_cyc(1'b0, 1'b0);
    issue_phase(3, -1, 0, 0, 2);
    step_cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, mk('0, 1'b0, 2, 1'b1, 1'b0));
    idle_cyc(3);
    start_cyc(2);
    load_cyc(1'b1, 1'b0);
    issue_phase(2, -1, 0, 0, 2 + N - 1);
    drain_cyc(1'b0, 1'b1, 1'b1);
    drain_cyc(1'b0, 1'b1, 1'b1);
    done_cyc(1'b0, 1'b0);
    idle_cyc(1);
    check_eq("abort_rerun_perf", perf_stall_cycles, 32'd0);

    // Five result pulses for k=3. The count saturates, and start is
    // ignored in DRAIN and in DONE.
    start_cyc(3);
    load_cyc(1'b0, 1'b1);
    issue_phase(3, -1, 0, 4, 3 + N - 1);
    drain_cyc(1'b1, 1'b0, 1'b0);
    done_cyc(1'b1, 1'b1);
    idle_cyc(3);

    // Reset during DRAIN.
    start_cyc(3);
    load_cyc(1'b0, 1'b0);
    issue_phase(3, 1, 1, 0, 3 + N - 1);
    drain_cyc(1'b0, 1'b0, 1'b0);
    drain_cyc(1'b0, 1'b0, 1'b0);
`ifdef SCHED_PERF_CNT_EN
    check_eq("pre_rst_perf", perf_stall_cycles, 32'd1);
`else
    check_eq("pre_rst_perf", perf_stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back(mk('0, 1'b0, 0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back('0);
    check_eq("post_rst_perf", perf_stall_cycles, 32'd0);
    idle_cyc(2);

    @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
